pt8211_tx: RTL
==============

# pt8211_tx

Serializer feeding the PT8211 16-bit stereo DAC from the 6 MHz PLL output clock. Accepts one stereo sample pair per frame over a valid/ready handshake and buffers it one deep. Generates the DAC bit clock (BCK), word select (WS) and serial data (DIN) in PT8211 LSB-justified format: 16 bits per channel, MSB first, no one-bit WS delay. Sits directly downstream of the PLL; the audio sample source sits upstream.

## Interface
- BCK_HALF, 2, clkin cycles per BCK half-period (≥1); default gives BCK = 1.5 MHz, fs = 46.875 kHz
- clkin  in  1  PLL output clock (6 MHz); all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request; sampled at frame boundaries only
- s_valid  in  1  sample pair valid
- s_ready  out  1  holding register empty
- s_left  in  16  left sample, two's complement, passed unmodified
- s_right  in  16  right sample, two's complement, passed unmodified
- bck  out  1  DAC bit clock
- ws  out  1  word select: 0 = left slot, 1 = right slot
- din  out  1  serial data
- underrun  out  1  one-cycle pulse when a frame starts with no sample held

## Operation
- Holding register (32 b) with `hold_full` flag. `s_ready = !hold_full`. Transfer on `s_valid & s_ready` sets `hold_full`. Loading the shift register clears `hold_full` on the next edge.
- The shift register (32 b) holds {left, right} and shifts MSB-first.
- Counters: `div_cnt` 0..BCK_HALF-1 and `bit_cnt` 0..31 (0-15 left, 16-31 right).
- bck toggles when `div_cnt` wraps. din/ws change only on the cycle bck falls, so the DAC samples on the bck rising edge.
- FSM states:
  - IDLE: bck=0, ws=0, din=0, counters held at 0. Go to RUN when `enable & hold_full`, loading the shift register from the holding register.
  - RUN: shift one bit per BCK period. At the falling edge ending bit 31 (frame boundary), choose the next state:
    - If `!enable`: go to IDLE. The holding contents are kept.
    - Else if `hold_full`: load the next pair and stay in RUN.
    - Else: load 32'h0, pulse underrun, and stay in RUN.
- At the frame boundary ws returns to 0 on the same falling edge that drives the new left MSB. ws goes to 1 on the falling edge that drives right-channel bit 15 (`bit_cnt` 16).
- A handshake in the same cycle as a frame-boundary load is allowed only if `hold_full` was already 0. The newly accepted pair is not the one being loaded.
- Reset mid-operation: all state returns to reset values immediately (async) and the buffered sample is discarded.

## Timing
- Reset values: bck=0, ws=0, din=0, s_ready=1, underrun=0, FSM=IDLE, `hold_full`=0.
- In IDLE, with enable high, a sample is accepted at edge t. `hold_full`=1 after t. The load happens at edge t+1, and din shows left bit 15 with ws=0 and bck=0 after edge t+1.
- Each bit lasts 2·BCK_HALF clkin cycles. A frame lasts 64·BCK_HALF cycles (128 at default).
- The first bck rise is BCK_HALF cycles after the load.
- underrun is high for exactly one clkin cycle, aligned with the boundary load.
- s_ready rises one cycle after each load.
- The upstream source has a full frame minus 1 cycle to supply the next pair without underrun.

## Structure
- `pt8211_pkg` contains:
  - state enum {IDLE, RUN}
  - SAMPLE_W = 16
  - FRAME_BITS = 32
  - `ws` channel encoding constants
- Sub-module `pt8211_bck_div`: the `div_cnt` counter. It outputs the bck level plus one-cycle `rise_en`/`fall_en` strobes, and is held in reset while in IDLE. The top level contains the FSM, the holding register and the shift register.

## Test plan
- Single pair L=16'h8001, R=16'h7FFE, enable=1, BCK_HALF=2:
  - captured on bck rises, left bits are 1000_0000_0000_0001 with ws=0, then right bits are 0111_1111_1111_1110 with ws=1.
  - the next frame is all-zero with one underrun pulse.
- Continuous source (a new pair every frame, e.g. counter values): no underrun pulses, ws period = 128 cycles, all decoded pairs match in order.
- Backpressure: hold s_valid high with 3 queued pairs → s_ready low between loads, each pair is emitted exactly once, and no pair is dropped or duplicated.
- enable dropped at bit 5 of a frame → the frame completes all 32 bits, then bck/ws/din go to 0 in IDLE. A pair already held stays held, and s_ready stays 0.
- Assert reset at bit 20 → bck/ws/din/underrun go to 0 and s_ready to 1 without waiting for a clkin edge. After release, the next frame starts from left MSB.
- BCK_HALF=1 → bck = clkin/2, frame = 64 cycles, and the serial data still matches the input.

Source files
------------

// File: rtl/pt8211_pkg.sv
// Shared types and constants for the PT8211 serializer.
package pt8211_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

  // Word-select levels for the two channel slots
  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/pt8211_if.sv
// Stereo sample valid/ready handshake from the audio source.
interface pt8211_if;

  logic                               s_valid;
  logic                               s_ready;
  logic [pt8211_pkg::SAMPLE_W-1:0]    s_left;
  logic [pt8211_pkg::SAMPLE_W-1:0]    s_right;

  modport master (
    output s_valid,
    output s_left,
    output s_right,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_left,
    input  s_right,
    output s_ready
  );

endinterface

// File: rtl/pt8211_bck_div.sv
// BCK generator: divides clkin by 2*BCK_HALF, parked low while not running.
module pt8211_bck_div #(
  parameter int unsigned BCK_HALF = 2
) (
  input  logic clkin,
  input  logic reset,
  input  logic run,
  output logic bck,
  output logic rise_en,
  output logic fall_en
);

  localparam int unsigned DIV_W = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  // Strobes mark the clkin edge on which bck will change level
  assign wrap    = run && (div_cnt == DIV_W'(BCK_HALF - 1));
  assign rise_en = wrap && !bck;
  assign fall_en = wrap && bck;

  // Half-period counter and bck level
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bck     <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      bck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bck     <= !bck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pt8211_tx.sv
// PT8211 LSB-justified serializer with a one-deep sample holding register.
module pt8211_tx
  import pt8211_pkg::*;
#(
  parameter int unsigned BCK_HALF = 2
) (
  input  logic     clkin,
  input  logic     reset,
  input  logic     enable,
  pt8211_if.slave  s_if,
  output logic     bck,
  output logic     ws,
  output logic     din,
  output logic     underrun
);

  state_t                  state;
  sample_pair_t            hold;
  logic                    hold_full;
  logic [FRAME_BITS-1:0]   shift;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic                    accept;
  logic                    rise_en;
  logic                    fall_en;
  logic                    last_bit;

  assign s_if.s_ready = !hold_full;
  assign accept       = s_if.s_valid && !hold_full;
  assign din          = shift[FRAME_BITS-1];
  assign last_bit     = (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));

  pt8211_bck_div #(
    .BCK_HALF (BCK_HALF)
  ) u_bck_div (
    .clkin   (clkin),
    .reset   (reset),
    .run     (state == RUN),
    .bck     (bck),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  // A single wrap can never be both a rising and a falling bck edge
  always_comb assert (!(rise_en && fall_en));

  // Frame FSM, holding register and MSB-first shift register
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      ws        <= WS_LEFT;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;

      // A load only happens while hold_full is set, so it never races an accept
      if (accept) begin
        hold      <= '{left: s_if.s_left, right: s_if.s_right};
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          ws      <= WS_LEFT;
          if (enable && hold_full) begin
            shift     <= hold;
            hold_full <= 1'b0;
            state     <= RUN;
          end
        end

        RUN: begin
          if (fall_en) begin
            if (last_bit) begin
              // Frame boundary: new left MSB and ws=left on the same falling edge
              bit_cnt <= '0;
              ws      <= WS_LEFT;
              if (!enable) begin
                shift <= '0;
                state <= IDLE;
              end else if (hold_full) begin
                shift     <= hold;
                hold_full <= 1'b0;
              end else begin
                shift    <= '0;
                underrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              shift   <= {shift[FRAME_BITS-2:0], 1'b0};
              if (bit_cnt == BIT_CNT_W'(SAMPLE_W - 1)) begin
                ws <= WS_RIGHT;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
